// File: rtl/rdata_collector_pkg.sv
// Shared types and sizing for the load-path read data collector.
// Default widths match the standard warp configuration used by the collector.
package rdata_collector_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int WARP_WIDTH     = 4;
  localparam int BLOCK_IDX_BITS = 4;
  localparam int BLOCK_BYTES    = 1 << BLOCK_IDX_BITS;

  // Width field needs at least one bit even for byte-wide registers.
  function automatic int calc_width_bits(input int reg_width);
    int w;
    w = $clog2(reg_width / 8);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int WIDTH_BITS = calc_width_bits(REG_WIDTH);

  typedef logic [WARP_WIDTH-1:0]                act_mask_t;
  typedef logic [REG_WIDTH*WARP_WIDTH-1:0]      warp_data_t;
  typedef logic [WIDTH_BITS-1:0]                width_t;
  typedef logic [BLOCK_IDX_BITS-1:0]            block_offset_t;
  typedef logic [BLOCK_BYTES*8-1:0]             block_data_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_WRITEBACK = 2'd2
  } state_t;

endpackage

// File: rtl/rdata_collector_extract.sv
// Pulls one thread's bytes out of a memory block and sign/zero-extends them.
// Bytes that would fall past the end of the block read as zero.
module rdata_extract #(
  parameter int RegWidth     = 32,
  parameter int BlockIdxBits = 4,
  parameter int WidthBits    = 2
) (
  input  logic [(2**BlockIdxBits)*8-1:0] block_data,
  input  logic [BlockIdxBits-1:0]        offset,
  input  logic [WidthBits-1:0]           width,
  input  logic                           sign_ext,
  output logic [RegWidth-1:0]            value
);

  localparam int RegBytes = RegWidth / 8;

  logic [RegWidth-1:0] window;
  logic                sign_bit;
  int                  nbytes;

  // Logical shift brings zeros in from the top, which covers the block-edge case.
  assign window = RegWidth'(block_data >> {offset, 3'b000});

  always_comb begin
    value    = '0;
    sign_bit = 1'b0;
    nbytes   = 1 << width;
    for (int b = 0; b < RegBytes; b++) begin
      if (b < nbytes) begin
        value[b*8 +: 8] = window[b*8 +: 8];
        if (b == nbytes - 1) sign_bit = window[b*8 + 7];
      end else begin
        value[b*8 +: 8] = {8{sign_ext & sign_bit}};
      end
    end
  end

endmodule

// File: rtl/rdata_collector.sv
// Collects block read responses for one warp load and hands the assembled
// register data to writeback.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting for a load request (req_ready_o=1)
// ST_COLLECT   | consuming memory responses until every thread is served
// ST_WRITEBACK | presenting wb_data_o until writeback accepts it
module rdata_collector
  import rdata_collector_pkg::*;
#(
  parameter int RegWidth     = REG_WIDTH,
  parameter int WarpWidth    = WARP_WIDTH,
  parameter int BlockIdxBits = BLOCK_IDX_BITS,
  localparam int WidthBits   = calc_width_bits(RegWidth)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [WarpWidth-1:0]              req_act_mask_i,
  input  logic [WidthBits-1:0]              req_width_i,
  input  logic                              req_signed_i,
  input  logic [WarpWidth*BlockIdxBits-1:0] req_block_offsets_i,
  input  logic                              mem_valid_i,
  output logic                              mem_ready_o,
  input  logic [WarpWidth-1:0]              mem_thread_mask_i,
  input  logic [(2**BlockIdxBits)*8-1:0]    mem_rdata_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [WarpWidth-1:0]              wb_act_mask_o,
  output logic [RegWidth*WarpWidth-1:0]     wb_data_o
);

  localparam int MaxWidth = $clog2(RegWidth / 8);

  state_t                            state;
  logic [WarpWidth-1:0]              pending;
  logic [WarpWidth-1:0]              mask_q;
  logic [WidthBits-1:0]              width_q;
  logic                              signed_q;
  logic [WarpWidth*BlockIdxBits-1:0] offsets_q;
  logic [RegWidth*WarpWidth-1:0]     data_q;
  logic [RegWidth*WarpWidth-1:0]     ext;
  logic [WarpWidth-1:0]              served;
  logic [WarpWidth-1:0]              pending_next;

  for (genvar t = 0; t < WarpWidth; t++) begin : g_thread
    rdata_extract #(
      .RegWidth    (RegWidth),
      .BlockIdxBits(BlockIdxBits),
      .WidthBits   (WidthBits)
    ) u_extract (
      .block_data(mem_rdata_i),
      .offset    (offsets_q[t*BlockIdxBits +: BlockIdxBits]),
      .width     (width_q),
      .sign_ext  (signed_q),
      .value     (ext[t*RegWidth +: RegWidth])
    );
  end

  // Only threads still pending take data, so a served slot is never overwritten.
  assign served       = mem_thread_mask_i & pending;
  assign pending_next = pending & ~served;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      req_ready_o <= 1'b1;
      mem_ready_o <= 1'b0;
      wb_valid_o  <= 1'b0;
      pending     <= '0;
      mask_q      <= '0;
      width_q     <= '0;
      signed_q    <= 1'b0;
      offsets_q   <= '0;
      data_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            mask_q      <= req_act_mask_i;
            width_q     <= (req_width_i > WidthBits'(MaxWidth)) ? WidthBits'(MaxWidth)
                                                                : req_width_i;
            signed_q    <= req_signed_i;
            offsets_q   <= req_block_offsets_i;
            data_q      <= '0;
            pending     <= req_act_mask_i;
            req_ready_o <= 1'b0;
            if (req_act_mask_i == '0) begin
              state      <= ST_WRITEBACK;
              wb_valid_o <= 1'b1;
            end else begin
              state       <= ST_COLLECT;
              mem_ready_o <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (mem_valid_i && mem_ready_o) begin
            for (int t = 0; t < WarpWidth; t++) begin
              if (served[t]) data_q[t*RegWidth +: RegWidth] <= ext[t*RegWidth +: RegWidth];
            end
            pending <= pending_next;
            if (pending_next == '0) begin
              state       <= ST_WRITEBACK;
              mem_ready_o <= 1'b0;
              wb_valid_o  <= 1'b1;
            end
          end
        end
        ST_WRITEBACK: begin
          if (wb_ready_i && wb_valid_o) begin
            state       <= ST_IDLE;
            wb_valid_o  <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
          mem_ready_o <= 1'b0;
          wb_valid_o  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_data_o     = data_q;
  assign wb_act_mask_o = mask_q;

endmodule

// File: doc/rdata_collector.md
Name: rdata_collector

Overview:
- Read-side counterpart of the write-data assembler in the load/store path.
- Accepts one warp load request: active mask, per-thread block byte offsets, access width and signedness.
- Collects one or more memory block read responses, extracts and extends each thread's bytes, then presents the assembled warp register data for writeback over a valid/ready handshake.
- Handles one request at a time.

Parameters:
- RegWidth, 32, register width in bits (multiple of 8).
- WarpWidth, 4, threads per warp.
- BlockIdxBits, 4, log2 of memory block size in bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_act_mask_i  in  WarpWidth  threads participating
- req_width_i  in  WidthBits  log2 access bytes; WidthBits = max(1, clog2(RegWidth/8))
- req_signed_i  in  1  1 = sign-extend, 0 = zero-extend
- req_block_offsets_i  in  WarpWidth*BlockIdxBits  per-thread byte offset in block
- mem_valid_i  in  1  memory response valid
- mem_ready_o  out  1  response consumed when high with mem_valid_i
- mem_thread_mask_i  in  WarpWidth  threads served by this response
- mem_rdata_i  in  (2^BlockIdxBits)*8  block read data, byte 0 in LSBs
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  writeback accepted
- wb_act_mask_o  out  WarpWidth  registered request active mask
- wb_data_o  out  RegWidth*WarpWidth  per-thread result, thread 0 in LSBs

Behaviour:
- FSM states:
  - IDLE: req_ready_o=1.
  - COLLECT: mem_ready_o=1.
  - WRITEBACK: wb_valid_o=1.
  - All three outputs are decoded from state only; none depends combinationally on its own handshake inputs.
- Reset (async, any state):
  - State goes to IDLE; pending mask, captured request fields and the data register clear to 0.
  - Outputs under reset: wb_valid_o=0, mem_ready_o=0, wb_data_o=0, wb_act_mask_o=0, req_ready_o=1.
  - A reset during COLLECT or WRITEBACK discards the in-flight request silently.
- IDLE, on req handshake:
  - Capture the request.
  - Clamp req_width_i to clog2(RegWidth/8) if larger.
  - Set pending = req_act_mask_i and clear the data register.
  - Next state: WRITEBACK if the mask is 0, else COLLECT.
- COLLECT, on mem handshake, for each thread t with mem_thread_mask_i[t] & pending[t]:
  - Take N = 1<<width bytes starting at byte offset[t]; bytes past the block end read as 0.
  - Extend to RegWidth: if signed and N*8 < RegWidth, replicate bit N*8-1; otherwise zero-extend.
  - Write the result to slot t and clear pending[t].
  - Threads not pending (inactive or already served) are ignored; earlier data is never overwritten.
  - When pending becomes 0 → WRITEBACK. wb_valid_o rises the cycle after the final mem handshake (1-cycle latency).
  - A response whose mask has no pending bits is consumed with no effect.
- WRITEBACK:
  - wb_data_o and wb_act_mask_o are held stable while wb_ready_i=0.
  - On handshake → IDLE. The next request is accepted no earlier than the following cycle (no back-to-back overlap).
- Slots of inactive threads output 0.
- mem_valid_i outside COLLECT is ignored and not consumed.

Decomposition:
- Shared package holds:
  - WidthBits and block-size localparams.
  - act_mask_t, warp_data_t, width_t, block_offset_t, block_data_t.
  - The state enum.
- Sub-module rdata_extract (combinational, instantiated per thread): inputs block data, offset, width, signed; output RegWidth value.
- The FSM and registers live in rdata_collector.

Test Plan:
All scenarios use RegWidth=32, WarpWidth=4, BlockIdxBits=4.
1. Full word load, single beat:
   - Stimulus: mask 1111, width 2, offsets 0/4/8/12; one response, mask 1111, rdata bytes i=0x00..0x0F.
   - Required: wb_valid_o one cycle after the handshake; t0=0x03020100, t1=0x07060504, t2=0x0B0A0908, t3=0x0F0E0D0C.
2. Byte load, signed vs unsigned:
   - Stimulus: mask 0001, width 0, offset 5, byte5=0x80.
   - Required: signed → t0=0xFFFFFF80; unsigned → t0=0x00000080; t1..t3=0.
3. Multi-beat collection:
   - Stimulus: mask 1011; beat 1 mask 0001 with byte0=0xAA; beat 2 mask 1011 with byte0=0x55 (width 0, offsets 0).
   - Required: t0=0x000000AA (not overwritten); wb_valid_o only after beat 2.
4. Empty mask:
   - Stimulus: mask 0000.
   - Required: wb_valid_o the cycle after the request; wb_data_o=0; mem_ready_o never high.
5. Backpressure and block-edge overflow:
   - Stimulus: width 2 (word), offset 14, bytes 14/15 = 0x34/0x12; wb_ready_i held low 5 cycles.
   - Required: t0=0x00001234, held stable for all 5 cycles; req_ready_o=0 throughout.
6. Reset mid-operation:
   - Stimulus: assert rst_i in COLLECT.
   - Required: immediately wb_valid_o=0, mem_ready_o=0, req_ready_o=1; a fresh request then completes normally.
